sr_latch_driver: RTL and testbench
==================================

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 4, sets the S/R pulse width in clk cycles (legal range 1..15).
REQ-002 Parameter GAP_CYCLES, default 2, sets the minimum all-low interval after a pulse (legal range 1..15).
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  always 1 when powered; functionally ignored.
REQ-006 ui_in  input  8  [0] cmd_strobe, [2:1] cmd (00 nop, 01 set, 10 reset, 11 toggle), [7:3] unused.
REQ-007 uio_in  input  8  [0] q_rb and [1] qn_rb (latch readback), [7:2] unused.
REQ-008 uo_out  output  8  [0] S, [1] R, [2] busy, [3] err, [4] q_exp, [7:5] tied 0.
REQ-009 uio_out  output  8  tied 0.
REQ-010 uio_oe  output  8  tied 0, all uio pins are inputs.

Function
REQ-011 The block SHALL pass cmd_strobe, q_rb and qn_rb through 2-flop synchronizers before use.
REQ-012 The block SHALL accept a command only on a synchronized 0->1 edge of cmd_strobe while in IDLE; edges seen outside IDLE are dropped, not queued.
REQ-013 FSM states: IDLE, PULSE, GAP, CHECK.
REQ-014 IDLE -> PULSE on an accepted set, reset or toggle; an accepted nop leaves the FSM in IDLE with no output change.
REQ-015 Toggle SHALL resolve to set when q_exp=0 and to reset when q_exp=1, decided at acceptance.
REQ-016 In PULSE, exactly one of S or R SHALL be high for exactly PULSE_CYCLES cycles, registered, starting the cycle after acceptance.
REQ-017 S and R SHALL never be high in the same cycle under any input sequence.
REQ-018 q_exp SHALL update to the commanded value on the PULSE -> GAP transition.
REQ-019 GAP holds S=R=0 for GAP_CYCLES cycles, then goes to CHECK.
REQ-020 CHECK lasts one cycle, then returns to IDLE.
REQ-021 busy SHALL be high in PULSE, GAP and CHECK, and low in IDLE.
REQ-022 The pulse/gap counter is 4 bits wide and SHALL load at each state entry and count down to 1; no wrap is possible in the legal range.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, S=0, R=0, busy=0, err=0, q_exp=0, and clear the counter and synchronizers.
REQ-024 Reset asserted mid-pulse SHALL drop S or R asynchronously; after release, no command is accepted until a fresh strobe edge.

Configuration
REQ-025 With LATCH_READBACK_EN defined, CHECK SHALL set err (sticky) if q_rb != q_exp or qn_rb != ~q_exp.
REQ-026 With LATCH_READBACK_EN defined, err SHALL clear only on reset, or on a later CHECK whose readback matches.
REQ-027 Without LATCH_READBACK_EN, the readback logic SHALL be absent, err SHALL be tied 0, and uio_in SHALL be unused.

Structure
REQ-028 Shared package sr_latch_pkg holds the state enum, the cmd encodings (CMD_NOP, CMD_SET, CMD_RST, CMD_TGL) and the counter width.
REQ-029 One sub-module, sync2, implements the 2-flop synchronizer and is instantiated per synchronized bit.

Verification
REQ-030 Reset then set strobe: S high 4 cycles starting 3 cycles after the strobe edge (2 sync + 1), R=0, q_exp=1, busy low after 4+2+1 cycles.
REQ-031 Toggle issued twice from reset: first produces an S pulse, second an R pulse; q_exp goes 1 then 0.
REQ-032 Strobe edge during PULSE: ignored, no second pulse, and S/R never both high.
REQ-033 LATCH_READBACK_EN, set command with q_rb=0, qn_rb=1: err=1 after CHECK; a following reset command with correct readback clears err.
REQ-034 rst_n asserted in cycle 2 of an R pulse: R=0 in the same cycle, and all outputs match reset values.
REQ-035 Nop strobe: no S/R activity, busy stays 0.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// Shared types for the SR latch driver: FSM states, command encodings, counter width.
// Optional feature macro used by the top: LATCH_READBACK_EN.
package sr_latch_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_SET = 2'b01;
    localparam logic [1:0] CMD_RST = 2'b10;
    localparam logic [1:0] CMD_TGL = 2'b11;

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer for one asynchronous input bit; output lags input by 2 clk edges.
// No handshake; the sampled level simply propagates. Both stages clear on rst_n.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives an external SR latch with fixed-width S/R pulses followed by an all-low gap, from strobed commands.
// Optional readback checking of the latch outputs is enabled by defining LATCH_READBACK_EN.
module sr_latch_driver
    import sr_latch_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             strb_s;
    logic             strb_prev_q, strb_prev_d;
    logic [1:0]       warm_q, warm_d;
    logic             strb_edge;
    logic [1:0]       cmd;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             q_exp_q, q_exp_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             busy;
    logic             err;

    sync2 u_sync_strb (.clk(clk), .rst_n(rst_n), .d(ui_in[0]), .q(strb_s));

    assign cmd = ui_in[2:1];

    // Until the synchronizer has refilled after reset, pretend the strobe was high,
    // so a strobe held across reset is never mistaken for a fresh edge.
    always_comb begin
        warm_d      = {warm_q[0], 1'b1};
        strb_prev_d = warm_q[1] ? strb_s : 1'b1;
    end

    assign strb_edge = warm_q[1] && strb_s && !strb_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        q_exp_d = q_exp_q;
        case (state_q)
            ST_IDLE: begin
                if (strb_edge && (cmd != CMD_NOP)) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                    dir_d   = (cmd == CMD_SET) || ((cmd == CMD_TGL) && !q_exp_q);
                end
            end
            ST_PULSE: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                    q_exp_d = dir_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // A single direction bit selects the driven line, so S and R are exclusive.
        s_d = (state_d == ST_PULSE) &&  dir_d;
        r_d = (state_d == ST_PULSE) && !dir_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q      <= 2'b00;
            strb_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            q_exp_q     <= 1'b0;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
        end else begin
            warm_q      <= warm_d;
            strb_prev_q <= strb_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            q_exp_q     <= q_exp_d;
            s_q         <= s_d;
            r_q         <= r_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

`ifdef LATCH_READBACK_EN
    logic q_rb_s, qn_rb_s;
    logic err_q, err_d;
    logic unused_in;

    sync2 u_sync_q  (.clk(clk), .rst_n(rst_n), .d(uio_in[0]), .q(q_rb_s));
    sync2 u_sync_qn (.clk(clk), .rst_n(rst_n), .d(uio_in[1]), .q(qn_rb_s));

    // err is re-evaluated only in CHECK, so it holds between checks and clears on a good one.
    always_comb begin
        err_d = err_q;
        if (state_q == ST_CHECK) begin
            err_d = (q_rb_s != q_exp_q) || (qn_rb_s != !q_exp_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err       = err_q;
    assign unused_in = ^{ena, ui_in[7:3], uio_in[7:2]};
`else
    logic unused_in;

    assign err       = 1'b0;
    assign unused_in = ^{ena, ui_in[7:3], uio_in};
`endif

    assign uo_out  = {3'b000, q_exp_q, err, busy, r_q, s_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: directed scenarios plus random command stream.
// Expected waveforms come from a cycle-offset timeline model of each command.
module tb_sr_latch_driver;

    localparam int P = 4;
    localparam int G = 2;
    localparam logic [1:0] C_NOP = 2'b00;
    localparam logic [1:0] C_SET = 2'b01;
    localparam logic [1:0] C_RST = 2'b10;
    localparam logic [1:0] C_TGL = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    logic q_model   = 1'b0;
    logic err_model = 1'b0;

    sr_latch_driver #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe raised now; offset k counts clock edges since. Command is accepted at
    // edge 3, the pulse occupies offsets 3..3+P-1, busy lasts through the gap and CHECK.
    task automatic run_cmd(input logic [1:0] cmd, input logic glitch, input logic bad_rb);
        logic act, dir, q_old, err_old, rb;
        act     = (cmd != C_NOP);
        dir     = (cmd == C_SET) ? 1'b1 : (cmd == C_RST) ? 1'b0 : ~q_model;
        q_old   = q_model;
        err_old = err_model;
        rb      = act ? dir : q_model;
        uio_in  = bad_rb ? {6'b0, rb, rb} : {6'b0, ~rb, rb};
        ui_in   = {5'b0, cmd, 1'b1};
        for (int k = 1; k <= 12; k++) begin
            logic s_e, r_e, b_e, q_e, e_e;
            tick();
            if (k == 2) ui_in[0] = 1'b0;
            if (glitch && k == 4) ui_in[0] = 1'b1;
            if (glitch && k == 6) ui_in[0] = 1'b0;
            s_e = act &&  dir && (k >= 3) && (k < 3 + P);
            r_e = act && !dir && (k >= 3) && (k < 3 + P);
            b_e = act && (k >= 3) && (k <= 3 + P + G);
            q_e = (act && k >= 3 + P) ? dir : q_old;
`ifdef LATCH_READBACK_EN
            e_e = (act && k >= 4 + P + G) ? bad_rb : err_old;
`else
            e_e = 1'b0;
`endif
            check("s",      {7'b0, uo_out[0]}, {7'b0, s_e});
            check("r",      {7'b0, uo_out[1]}, {7'b0, r_e});
            check("busy",   {7'b0, uo_out[2]}, {7'b0, b_e});
            check("err",    {7'b0, uo_out[3]}, {7'b0, e_e});
            check("q_exp",  {7'b0, uo_out[4]}, {7'b0, q_e});
            check("sr_excl", {7'b0, uo_out[0] & uo_out[1]}, 8'h00);
            check("hi_tied", {5'b0, uo_out[7:5]}, 8'h00);
        end
        if (act) q_model = dir;
`ifdef LATCH_READBACK_EN
        if (act) err_model = bad_rb;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_async", uo_out, 8'h00);
        tick();
        tick();
        rst_n     = 1'b1;
        q_model   = 1'b0;
        err_model = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h02;
        tick();
        tick();
        check("reset_uo",  uo_out,  8'h00);
        check("uio_out",   uio_out, 8'h00);
        check("uio_oe",    uio_oe,  8'h00);
        rst_n = 1'b1;
        tick();
        tick();
        tick();

        // Set after reset, then two toggles from reset.
        run_cmd(C_SET, 1'b0, 1'b0);
        do_reset();
        run_cmd(C_TGL, 1'b0, 1'b0);
        run_cmd(C_TGL, 1'b0, 1'b0);

        // Strobe edge arriving mid-pulse is dropped.
        run_cmd(C_SET, 1'b1, 1'b0);
        run_cmd(C_RST, 1'b1, 1'b0);

        // Nop: no activity.
        run_cmd(C_NOP, 1'b0, 1'b0);

`ifdef LATCH_READBACK_EN
        run_cmd(C_SET, 1'b0, 1'b1);
        run_cmd(C_RST, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 16; i++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            run_cmd(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset asserted during the second cycle of an R pulse.
        run_cmd(C_SET, 1'b0, 1'b0);
        ui_in = {5'b0, C_RST, 1'b1};
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) ui_in[0] = 1'b0;
        end
        check("r_pulse_c2", {7'b0, uo_out[1]}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("rst_mid_pulse", uo_out, 8'h00);
        tick();
        rst_n     = 1'b1;
        q_model   = 1'b0;
        err_model = 1'b0;
        tick();
        check("post_rst", uo_out, 8'h00);

        // Strobe held high across reset release is not a fresh edge.
        ui_in = {5'b0, C_SET, 1'b1};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("held_strb", uo_out, 8'h00);
        end
        ui_in = 8'h00;
        tick();
        tick();
        tick();
        run_cmd(C_TGL, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
